if_id_reg: RTL and testbench
============================

Name: if_id_reg

Overview:
- IF/ID pipeline register of the 5-stage MIPS core.
- Sits directly downstream of the fetch stage: captures its instruction word and PC+4 (NPC) each cycle and presents them to the decode stage with a valid flag.
- Supports stall (hold) and flush (bubble) from the hazard/branch logic.
- Provides pre-sliced instruction fields and the instruction's own PC.

Parameters:
- NOP_INSTR, 32'h0000_0000, instruction word injected on reset/flush (sll $0,$0,0).
- RESET_NPC, 32'h0000_3004, NPCOut value after reset (reset PC 0x3000 + 4).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- InstrIn  input  32  instruction word from fetch.
- NPCIn  input  32  PC+4 from fetch.
- WriteEnable  input  1  1 = load new values; 0 = hold (stall). Driven by the same hazard signal as the fetch PC write enable.
- Flush  input  1  1 = replace contents with a bubble at the next edge.
- InstrOut  output  32  registered instruction.
- NPCOut  output  32  registered PC+4.
- PCOut  output  32  NPCOut - 4.
- Valid  output  1  1 = InstrOut is a real fetched instruction; 0 = bubble.
- Op  output  6  InstrOut[31:26].
- Rs  output  5  InstrOut[25:21].
- Rt  output  5  InstrOut[20:16].
- Rd  output  5  InstrOut[15:11].
- Shamt  output  5  InstrOut[10:6].
- Funct  output  6  InstrOut[5:0].
- Imm16  output  16  InstrOut[15:0].
- StallCount  output  32  performance counter (see Optional Feature).
- FlushCount  output  32  performance counter (see Optional Feature).

Behaviour:
- All state updates on the rising clk edge. Priority per edge: rst > Flush > hold (WriteEnable=0) > load.
- Reset (rst=1):
  - InstrOut=NOP_INSTR, NPCOut=RESET_NPC, Valid=0.
  - StallCount=0, FlushCount=0.
  - Reset is honoured regardless of Flush/WriteEnable. Asserting it mid-stall discards held contents.
- Flush=1 (rst=0): InstrOut=NOP_INSTR, Valid=0. NPCOut loads NPCIn if WriteEnable=1, otherwise holds.
  - Flush with WriteEnable=0 still inserts the bubble; flush wins over stall.
- Hold (Flush=0, WriteEnable=0): all registers keep their value, including Valid.
  - A bubble stays a bubble; a valid instruction stays valid.
- Load (Flush=0, WriteEnable=1): InstrOut<=InstrIn, NPCOut<=NPCIn, Valid<=1.
- Latency: exactly 1 cycle from fetch output to register output. No combinational path from any input to any output.
- Field outputs (Op..Imm16) are combinational slices of the registered InstrOut and change in the same cycle as InstrOut. After reset or flush they are all zero when NOP_INSTR=0.
- PCOut = NPCOut - 32'd4, modulo 2^32. NPCOut=0 gives PCOut=32'hFFFF_FFFC; no trap or saturation.
- Back-to-back flushes are allowed. Each one re-inserts the bubble. Valid returns to 1 only on the first load edge.
- Inputs are sampled only at the edge. X on InstrIn/NPCIn during hold or flush has no effect on outputs.

Optional Feature:
- Macro: IFID_PERF_CNT_EN.
- Defined:
  - StallCount increments by 1 on every edge with rst=0, Flush=0, WriteEnable=0.
  - FlushCount increments by 1 on every edge with rst=0, Flush=1.
  - Both saturate at 32'hFFFF_FFFF (no wrap) and clear only on rst.
- Undefined: both ports remain in the port list, driven constant 0; no counter flops are synthesised.

Test Plan:
- Reset: rst=1 for 2 cycles with InstrIn=32'h2008_0005 -> InstrOut=0, NPCOut=32'h0000_3004, PCOut=32'h0000_3000, Valid=0, counters=0.
- Load: rst=0, WriteEnable=1, InstrIn=32'h0109_5020, NPCIn=32'h0000_3008 -> next edge InstrOut=32'h0109_5020, Valid=1, Op=0, Rs=8, Rt=9, Rd=10, Funct=32'h20, PCOut=32'h0000_3004.
- Stall: after load, WriteEnable=0 for 3 cycles while InstrIn changes to 32'hDEAD_BEEF -> outputs unchanged for all 3 cycles; StallCount=3 with macro, 0 without.
- Flush during stall: Flush=1, WriteEnable=0, NPCIn=32'h0000_3010 -> InstrOut=0, Valid=0, NPCOut unchanged. Next cycle Flush=0, WriteEnable=1, InstrIn=32'h1000_FFFF -> Valid=1, Imm16=16'hFFFF, Op=6'h04.
- Wrap: load NPCIn=32'h0000_0000 -> PCOut=32'hFFFF_FFFC.
- Saturation (macro defined): force StallCount to 32'hFFFF_FFFE, then stall 3 cycles -> StallCount=32'hFFFF_FFFF and stays there. rst=1 mid-stall -> counters=0, Valid=0 at the next edge.

Source files
------------

// File: rtl/if_id_reg.sv
// IF/ID pipeline register for the 5-stage MIPS core.
// Captures the fetched instruction and PC+4 each cycle, supports stall (hold)
// and flush (bubble insertion), and presents pre-sliced instruction fields.
// Optional stall/flush performance counters are enabled by defining
// IFID_PERF_CNT_EN; otherwise StallCount/FlushCount are tied to zero.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [31:0] RESET_NPC = 32'h0000_3004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrIn,
  input  logic [31:0] NPCIn,
  input  logic        WriteEnable,
  input  logic        Flush,
  output logic [31:0] InstrOut,
  output logic [31:0] NPCOut,
  output logic [31:0] PCOut,
  output logic        Valid,
  output logic [5:0]  Op,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [4:0]  Shamt,
  output logic [5:0]  Funct,
  output logic [15:0] Imm16,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
);

  logic [31:0] instr_reg;
  logic [31:0] npc_reg;
  logic        valid_reg;

  // Pipeline state: reset beats flush, flush beats stall, stall beats load.
  // A flush still lets NPC advance when the stage is otherwise enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg <= NOP_INSTR;
      npc_reg   <= RESET_NPC;
      valid_reg <= 1'b0;
    end else if (Flush) begin
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
      if (WriteEnable) begin
        npc_reg <= NPCIn;
      end
    end else if (WriteEnable) begin
      instr_reg <= InstrIn;
      npc_reg   <= NPCIn;
      valid_reg <= 1'b1;
    end
  end

  assign InstrOut = instr_reg;
  assign NPCOut   = npc_reg;
  assign Valid    = valid_reg;

  // The instruction's own PC; wraps modulo 2^32 with no special casing.
  assign PCOut = npc_reg - 32'd4;

  // Field slices come straight from the registered word, so they update in
  // the same cycle as InstrOut and carry no input-to-output path.
  assign Op    = instr_reg[31:26];
  assign Rs    = instr_reg[25:21];
  assign Rt    = instr_reg[20:16];
  assign Rd    = instr_reg[15:11];
  assign Shamt = instr_reg[10:6];
  assign Funct = instr_reg[5:0];
  assign Imm16 = instr_reg[15:0];

`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  // Saturating event counters; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else if (Flush) begin
      if (flush_cnt_reg != 32'hFFFF_FFFF) begin
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
    end else if (!WriteEnable) begin
      if (stall_cnt_reg != 32'hFFFF_FFFF) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign StallCount = stall_cnt_reg;
  assign FlushCount = flush_cnt_reg;
`else
  assign StallCount = 32'd0;
  assign FlushCount = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Testbench for if_id_reg: directed scenarios plus randomized traffic, all
// checked against a behavioural model of the register's update rules.
module tb_if_id_reg;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] RNPC = 32'h0000_3004;
  localparam logic [31:0] MAXC = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrIn, NPCIn;
  logic        WriteEnable, Flush;
  logic [31:0] InstrOut, NPCOut, PCOut;
  logic        Valid;
  logic [5:0]  Op, Funct;
  logic [4:0]  Rs, Rt, Rd, Shamt;
  logic [15:0] Imm16;
  logic [31:0] StallCount, FlushCount;

  int tests = 0;
  int fails = 0;

  // Model state
  logic [31:0] m_instr, m_npc, m_stall, m_flush;
  logic        m_valid;

  always #5 clk = ~clk;

  if_id_reg dut (
    .clk(clk), .rst(rst), .InstrIn(InstrIn), .NPCIn(NPCIn),
    .WriteEnable(WriteEnable), .Flush(Flush),
    .InstrOut(InstrOut), .NPCOut(NPCOut), .PCOut(PCOut), .Valid(Valid),
    .Op(Op), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Funct(Funct),
    .Imm16(Imm16), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  function automatic logic [31:0] exp_stall();
`ifdef IFID_PERF_CNT_EN
    return m_stall;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_flush();
`ifdef IFID_PERF_CNT_EN
    return m_flush;
`else
    return 32'd0;
`endif
  endfunction

  // Apply one cycle of inputs, advance the model, and step past the edge.
  task automatic drive(input logic r, input logic we, input logic fl,
                       input logic [31:0] ins, input logic [31:0] npc);
    rst = r; WriteEnable = we; Flush = fl; InstrIn = ins; NPCIn = npc;
    if (r) begin
      m_instr = NOP; m_npc = RNPC; m_valid = 1'b0; m_stall = 0; m_flush = 0;
    end else if (fl) begin
      m_instr = NOP; m_valid = 1'b0;
      if (we) m_npc = npc;
      if (m_flush != MAXC) m_flush = m_flush + 1;
    end else if (!we) begin
      if (m_stall != MAXC) m_stall = m_stall + 1;
    end else begin
      m_instr = ins; m_npc = npc; m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h2008_0005, 32'h0000_1234);
      tests++; if (InstrOut !== NOP) begin fails++; $display("FAIL reset_instr got %h want %h", InstrOut, NOP); end
      tests++; if (NPCOut !== 32'h0000_3004) begin fails++; $display("FAIL reset_npc got %h want %h", NPCOut, 32'h0000_3004); end
      tests++; if (PCOut !== 32'h0000_3000) begin fails++; $display("FAIL reset_pc got %h want %h", PCOut, 32'h0000_3000); end
      tests++; if (Valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", Valid); end
      tests++; if (StallCount !== 0 || FlushCount !== 0) begin fails++; $display("FAIL reset_cnt got %h/%h want 0/0", StallCount, FlushCount); end
      $display("[TB] reset cycle %0d instr=%h npc=%h valid=%b", i, InstrOut, NPCOut, Valid);
    end
  endtask

  task automatic test_load();
    // Inputs must not reach outputs before the edge.
    rst = 1'b0; WriteEnable = 1'b1; Flush = 1'b0;
    InstrIn = 32'h0109_5020; NPCIn = 32'h0000_3008;
    #1;
    tests++; if (InstrOut !== NOP || Valid !== 1'b0) begin fails++; $display("FAIL load_comb_path got %h/%b want %h/0", InstrOut, Valid, NOP); end
    drive(1'b0, 1'b1, 1'b0, 32'h0109_5020, 32'h0000_3008);
    tests++; if (InstrOut !== 32'h0109_5020) begin fails++; $display("FAIL load_instr got %h want 01095020", InstrOut); end
    tests++; if (Valid !== 1'b1) begin fails++; $display("FAIL load_valid got %b want 1", Valid); end
    tests++; if ({Op, Rs, Rt, Rd, Funct} !== {6'd0, 5'd8, 5'd9, 5'd10, 6'h20}) begin
      fails++; $display("FAIL load_fields got op=%h rs=%0d rt=%0d rd=%0d fn=%h want 0/8/9/10/20", Op, Rs, Rt, Rd, Funct); end
    tests++; if (PCOut !== 32'h0000_3004) begin fails++; $display("FAIL load_pc got %h want 00003004", PCOut); end
    $display("[TB] load instr=%h npc=%h pc=%h valid=%b", InstrOut, NPCOut, PCOut, Valid);
  endtask

  task automatic test_stall();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_300C);
      tests++; if (InstrOut !== 32'h0109_5020 || NPCOut !== 32'h0000_3008 || Valid !== 1'b1) begin
        fails++; $display("FAIL stall_hold got %h/%h/%b want 01095020/00003008/1", InstrOut, NPCOut, Valid); end
`ifdef IFID_PERF_CNT_EN
      tests++; if (StallCount !== i) begin fails++; $display("FAIL stall_count got %0d want %0d", StallCount, i); end
`else
      tests++; if (StallCount !== 0) begin fails++; $display("FAIL stall_count got %0d want 0", StallCount); end
`endif
      $display("[TB] stall %0d instr=%h valid=%b stalls=%0d", i, InstrOut, Valid, StallCount);
    end
  endtask

  task automatic test_flush_stall();
    drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_3010);
    tests++; if (InstrOut !== NOP || Valid !== 1'b0) begin fails++; $display("FAIL flush_bubble got %h/%b want 0/0", InstrOut, Valid); end
    tests++; if (NPCOut !== 32'h0000_3008) begin fails++; $display("FAIL flush_npc_hold got %h want 00003008", NPCOut); end
    tests++; if ({Op, Rs, Rt, Rd, Shamt, Funct, Imm16} !== 0) begin fails++; $display("FAIL flush_fields got nonzero op=%h imm=%h", Op, Imm16); end
    tests++; if (FlushCount !== exp_flush()) begin fails++; $display("FAIL flush_count got %0d want %0d", FlushCount, exp_flush()); end
    $display("[TB] flush-during-stall instr=%h npc=%h valid=%b", InstrOut, NPCOut, Valid);
    drive(1'b0, 1'b1, 1'b0, 32'h1000_FFFF, 32'h0000_3010);
    tests++; if (Valid !== 1'b1 || Imm16 !== 16'hFFFF || Op !== 6'h04) begin
      fails++; $display("FAIL flush_reload got v=%b imm=%h op=%h want 1/ffff/04", Valid, Imm16, Op); end
    $display("[TB] reload after flush instr=%h valid=%b", InstrOut, Valid);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 32'h2108_0001 + i, 32'h0000_4000 + 4 * i);
      tests++; if (Valid !== 1'b0 || InstrOut !== NOP) begin fails++; $display("FAIL b2b_flush got %h/%b want 0/0", InstrOut, Valid); end
      tests++; if (NPCOut !== 32'h0000_4000 + 4 * i) begin fails++; $display("FAIL b2b_npc got %h want %h", NPCOut, 32'h0000_4000 + 4 * i); end
      $display("[TB] b2b flush %0d npc=%h flushes=%0d", i, NPCOut, FlushCount);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h2108_0007, 32'h0000_4010);
    tests++; if (Valid !== 1'b1 || InstrOut !== 32'h2108_0007) begin fails++; $display("FAIL b2b_load got %h/%b want 21080007/1", InstrOut, Valid); end
    tests++; if (FlushCount !== exp_flush()) begin fails++; $display("FAIL b2b_count got %0d want %0d", FlushCount, exp_flush()); end
    $display("[TB] b2b load instr=%h valid=%b", InstrOut, Valid);
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000);
    tests++; if (PCOut !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pc got %h want fffffffc", PCOut); end
    $display("[TB] wrap npc=%h pc=%h", NPCOut, PCOut);
  endtask

`ifdef IFID_PERF_CNT_EN
  task automatic test_saturation();
    force dut.stall_cnt_reg = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_reg;
    m_stall = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, $urandom, $urandom);
      tests++; if (StallCount !== MAXC) begin fails++; $display("FAIL sat_stall got %h want ffffffff", StallCount); end
      $display("[TB] saturate %0d stalls=%h", i, StallCount);
    end
    drive(1'b1, 1'b0, 1'b0, $urandom, $urandom);
    tests++; if (StallCount !== 0 || FlushCount !== 0 || Valid !== 1'b0) begin
      fails++; $display("FAIL sat_reset got %h/%h/%b want 0/0/0", StallCount, FlushCount, Valid); end
    $display("[TB] reset mid-stall stalls=%0d valid=%b", StallCount, Valid);
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic r, we, fl;
      logic [31:0] ins, npc;
      r   = ($urandom_range(0, 31) == 0);
      we  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 4) == 0);
      ins = $urandom;
      npc = $urandom;
      drive(r, we, fl, ins, npc);
      tests++; if (InstrOut !== m_instr || NPCOut !== m_npc || Valid !== m_valid || PCOut !== m_npc - 32'd4) begin
        fails++; $display("FAIL rand_state[%0d] got %h/%h/%b/%h want %h/%h/%b/%h", i,
                          InstrOut, NPCOut, Valid, PCOut, m_instr, m_npc, m_valid, m_npc - 32'd4); end
      tests++; if ({Op, Rs, Rt, Rd, Shamt, Funct} !== m_instr || Imm16 !== m_instr[15:0]) begin
        fails++; $display("FAIL rand_fields[%0d] got %h/%h want %h", i, {Op, Rs, Rt, Rd, Shamt, Funct}, Imm16, m_instr); end
      tests++; if (StallCount !== exp_stall() || FlushCount !== exp_flush()) begin
        fails++; $display("FAIL rand_cnt[%0d] got %0d/%0d want %0d/%0d", i, StallCount, FlushCount, exp_stall(), exp_flush()); end
      $display("[TB] rand %0d rst=%b we=%b fl=%b instr=%h npc=%h valid=%b", i, r, we, fl, InstrOut, NPCOut, Valid);
    end
  endtask

  initial begin
    rst = 1'b1; WriteEnable = 1'b0; Flush = 1'b0; InstrIn = 32'd0; NPCIn = 32'd0;
    m_instr = NOP; m_npc = RNPC; m_valid = 1'b0; m_stall = 0; m_flush = 0;
    test_reset();
    test_load();
    test_stall();
    test_flush_stall();
    test_back_to_back();
    test_wrap();
`ifdef IFID_PERF_CNT_EN
    test_saturation();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
